// File: rtl/if_id_buf_pkg.sv
// ----------------------------------------------------------------------------
// if_id_buf_pkg
// Shared definitions for the IF/ID pipeline buffer: instruction and
// instruction-address bus widths, the NOP encoding shown to decode when no
// entry is valid, the reset active level, and the packed storage entry type.
// No ports (package).
// ----------------------------------------------------------------------------
package if_id_buf_pkg;

  localparam int INST_W  = 32;
  localparam int ADDR_W  = 64;
  localparam int ENTRY_W = INST_W + ADDR_W;

  // RV32I "addi x0, x0, 0"
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

  // rst_n is active-low.
  localparam logic RST_ACT_LVL = 1'b0;

  typedef logic [INST_W-1:0] inst_bus_t;
  typedef logic [ADDR_W-1:0] inst_addr_bus_t;

  typedef struct packed {
    inst_bus_t      inst;
    inst_addr_bus_t pc;
  } entry_t;

endpackage

// File: rtl/if_id_buf_if.sv
// ----------------------------------------------------------------------------
// if_id_buf_if
// Fetch-side and decode-side handshake signals of the IF/ID buffer.
//   in_valid/in_inst/in_pc  : fetch presents an instruction
//   in_ready                : buffer accepts it this cycle
//   out_valid/out_inst/out_pc: head entry presented to decode
//   out_ready               : decode consumes the head entry
// Modports: master = surrounding pipeline (fetch + decode), slave = buffer.
// ----------------------------------------------------------------------------
interface if_id_buf_if;
  import if_id_buf_pkg::*;

  logic           in_valid;
  inst_bus_t      in_inst;
  inst_addr_bus_t in_pc;
  logic           in_ready;
  logic           out_valid;
  inst_bus_t      out_inst;
  inst_addr_bus_t out_pc;
  logic           out_ready;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc
  );

endinterface

// File: rtl/if_id_fifo_mem.sv
// ----------------------------------------------------------------------------
// if_id_fifo_mem
// DEPTH x 96-bit register array holding {inst, pc} entries. One synchronous
// write port, one asynchronous read port. Contents are not reset.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : entry to store
//   raddr_i  : read index
//   rdata_o  : entry at raddr_i (combinational)
// ----------------------------------------------------------------------------
module if_id_fifo_mem
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  // Write port: store the accepted entry.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: head entry is visible without a clock edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buf.sv
// ----------------------------------------------------------------------------
// if_id_buf
// Circular buffer between fetch and decode. Entries leave in acceptance
// order with one cycle of latency (no input-to-output bypass). A flush
// (taken jump) empties the buffer and drops the instruction offered in the
// same cycle. Legal DEPTH values: 2 or 4.
// Ports:
//   clk         : clock, all state on posedge
//   rst_n       : synchronous active-low reset (priority over everything)
//   flush_i     : discard buffered and incoming entries
//   occupancy_o : current entry count
//   bus         : fetch/decode handshake (slave modport)
// ----------------------------------------------------------------------------
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int        DEPTH    = 2,
  parameter inst_bus_t NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] occupancy_o,
  if_id_buf_if.slave             bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic   push_s;
  logic   pop_s;
  logic   in_ready_s;
  logic   out_valid_s;
  entry_t wdata_s;
  entry_t rdata_s;

  // Handshake qualifiers. in_ready never looks at out_ready, so a full
  // buffer does not accept even when decode pops in the same cycle.
  assign in_ready_s  = (count_q < DEPTH_C) && !flush_i;
  assign out_valid_s = (count_q != CNT_ZERO);
  assign push_s      = bus.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && bus.out_ready && !flush_i;

  assign wdata_s = '{inst: bus.in_inst, pc: bus.in_pc};

  // Next-state for pointers and count; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n == RST_ACT_LVL) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Decode sees a NOP at PC 0 whenever the buffer is empty.
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_inst  = out_valid_s ? rdata_s.inst : NOP_INST;
  assign bus.out_pc    = out_valid_s ? rdata_s.pc   : {ADDR_W{1'b0}};
  assign occupancy_o   = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
// ----------------------------------------------------------------------------
// tb_if_id_buf
// Directed bench for if_id_buf (DEPTH=2). Inputs change on the falling edge;
// outputs are compared 1 ns later, i.e. they reflect state from earlier
// rising edges plus the current flush_i. Each instruction word is derived
// from its PC so that inst and pc can be checked together.
// ----------------------------------------------------------------------------
module tb_if_id_buf;
  import if_id_buf_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] IKEY = 32'h1234_0000;

  logic       clk;
  logic       rst_n;
  logic       flush_i;
  logic [1:0] occupancy;

  int tests_run;
  int tests_failed;

  if_id_buf_if bus ();

  if_id_buf #(
    .DEPTH    (2),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .occupancy_o (occupancy),
    .bus         (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic        out_ready;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic        exp_ready;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [63:0] pc, input logic ordy);
    rst_n         = r;
    flush_i       = f;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = pc[31:0] ^ IKEY;
    bus.out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [63:0] epc,
                           input logic er, input logic [1:0] eocc);
    logic [31:0] einst;
    einst = ev ? (epc[31:0] ^ IKEY) : NOP;
    chk({tag, " out_valid"}, {63'd0, bus.out_valid}, {63'd0, ev});
    chk({tag, " out_pc"},    bus.out_pc, ev ? epc : 64'd0);
    chk({tag, " out_inst"},  {32'd0, bus.out_inst}, {32'd0, einst});
    chk({tag, " in_ready"},  {63'd0, bus.in_ready}, {63'd0, er});
    chk({tag, " occupancy"}, {62'd0, occupancy}, {62'd0, eocc});
  endtask

  initial begin
    logic [63:0] base;
    tests_run    = 0;
    tests_failed = 0;
    base         = 64'h0000_0000_8000_0000;

    //             rst   fl    iv    in_pc         ordy  ev    exp_pc        er    occ
    // reset held (second reset edge follows this vector)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'd0,        1'b0, 1'b0, 64'd0,        1'b1, 2'd0};
    // stream: each PC appears one cycle after it is offered
    vecs[1]  = '{1'b1, 1'b0, 1'b1, base,         1'b1, 1'b0, 64'd0,        1'b1, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, base + 64'd4, 1'b1, 1'b1, base,         1'b1, 2'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, base + 64'd8, 1'b1, 1'b1, base + 64'd4, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'd0,        1'b1, 1'b1, base + 64'd8, 1'b1, 2'd1};
    // full: two pushes with decode held, third push refused
    vecs[5]  = '{1'b1, 1'b0, 1'b1, base,         1'b0, 1'b0, 64'd0,        1'b1, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, base + 64'd4, 1'b0, 1'b1, base,         1'b1, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, base + 64'd8, 1'b0, 1'b1, base,         1'b0, 2'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, base + 64'd8, 1'b1, 1'b1, base,         1'b0, 2'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'd0,        1'b1, 1'b1, base + 64'd4, 1'b1, 2'd1};
    // flush with two entries held and a simultaneous offer of 0x80000010
    vecs[10] = '{1'b1, 1'b0, 1'b1, base + 64'h20, 1'b0, 1'b0, 64'd0,        1'b1, 2'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, base + 64'h24, 1'b0, 1'b1, base + 64'h20, 1'b1, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, base + 64'h10, 1'b1, 1'b1, base + 64'h20, 1'b0, 2'd2};
    // reset mid-stream with two entries held
    vecs[13] = '{1'b1, 1'b0, 1'b1, base + 64'h30, 1'b0, 1'b0, 64'd0,        1'b1, 2'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, base + 64'h34, 1'b0, 1'b1, base + 64'h30, 1'b1, 2'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, base + 64'h38, 1'b1, 1'b1, base + 64'h30, 1'b0, 2'd2};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 64'd0,        1'b0, 1'b0, 64'd0,        1'b1, 2'd0};

    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].in_pc, vecs[i].out_ready);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_ready, vecs[i].exp_occ);
    end

    // Steady push+pop at count 1 across several pointer wraps.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_9000_0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_9000_0000 + 64'(4 * (k + 1)), 1'b1);
      #1;
      check_out($sformatf("wrap%0d", k), 1'b1,
                64'h0000_0000_9000_0000 + 64'(4 * k), 1'b1, 2'd1);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    #1;
    check_out("wrap_last", 1'b1, 64'h0000_0000_9000_0028, 1'b1, 2'd1);
    @(negedge clk);
    #1;
    check_out("wrap_drained", 1'b0, 64'd0, 1'b1, 2'd0);

    // in_ready drops with flush even when empty; flushed offer is dropped.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 64'h0000_0000_A000_0000, 1'b1);
    #1;
    check_out("flush_empty", 1'b0, 64'd0, 1'b0, 2'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    #1;
    check_out("after_flush_empty", 1'b0, 64'd0, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 Parameter DEPTH, 2, number of buffered fetch entries (legal values 2 or 4).
REQ-002 Parameter NOP_INST, 32'h00000013, instruction driven on out_inst when out_valid=0.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 in_inst  input  32  fetched instruction.
REQ-007 in_pc  input  64  PC of in_inst.
REQ-008 in_ready  output  1  buffer accepts in_inst/in_pc this cycle.
REQ-009 flush_i  input  1  jump taken; discard all buffered and incoming entries.
REQ-010 out_valid  output  1  out_inst/out_pc hold a valid entry for decode.
REQ-011 out_inst  output  32  head-entry instruction, or NOP_INST when out_valid=0.
REQ-012 out_pc  output  64  head-entry PC, or 0 when out_valid=0.
REQ-013 out_ready  input  1  decode consumes the head entry this cycle (deasserted on pipeline hold).
REQ-014 occupancy  output  log2(DEPTH)+1  current entry count, for hazard/debug logic.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries {inst[31:0], pc[63:0]} with write pointer, read pointer and count registers.
REQ-016 in_ready SHALL equal (count < DEPTH) AND NOT flush_i, combinational from registered state and flush_i only; no dependency on out_ready.
REQ-017 Push SHALL occur on a clock edge where in_valid AND in_ready; entry written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 Pop SHALL occur on a clock edge where out_valid AND out_ready AND NOT flush_i; rd_ptr increments modulo DEPTH.
REQ-019 out_valid SHALL equal (count != 0); out_inst/out_pc SHALL be read from rd_ptr entry; no input-to-output bypass.
REQ-020 Latency SHALL be one cycle: entry pushed at edge N is visible on outputs after edge N when buffer was empty.
REQ-021 Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); push only -> count+1; pop only -> count-1; push and pop same edge -> count unchanged.
REQ-022 Push in FULL SHALL be impossible (in_ready=0); pop in EMPTY SHALL be impossible (out_valid=0).
REQ-023 Pointer wrap SHALL be modulo DEPTH with no lost or duplicated entries across wrap.
REQ-024 flush_i=1 at an edge SHALL clear count, wr_ptr, rd_ptr to 0, discard in_valid data, and override any simultaneous push/pop; out_valid=0 in the following cycle.
REQ-025 Entries SHALL leave in strict program order of acceptance.

Reset
REQ-026 rst_n=0 at an edge SHALL set count=0, wr_ptr=0, rd_ptr=0; storage contents need not be cleared.
REQ-027 After reset: out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1 (flush_i=0), occupancy=0.
REQ-028 Reset mid-operation SHALL discard all entries; reset has priority over flush, push and pop.

Structure
REQ-029 InstBus, InstAddrBus widths, NOP_INST value and reset-level macro SHALL live in the shared defines header.
REQ-030 One sub-module is natural: if_id_fifo_mem (DEPTH x 96-bit register array, one write port, one async read port); control stays in if_id_buf.

Verification
REQ-031 Reset: hold rst_n=0 two cycles -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1.
REQ-032 Stream: in_valid=1, out_ready=1, pc 0x80000000,+4,+8 -> out_pc 0x80000000,0x80000004,0x80000008 on consecutive cycles, each one cycle late.
REQ-033 Full: out_ready=0, push pc 0x80000000,0x80000004 -> occupancy=2, in_ready=0, third push (0x80000008) not accepted; release out_ready -> outputs 0x80000000 then 0x80000004.
REQ-034 Flush: buffer holds 2 entries, flush_i=1 with in_valid=1 pc 0x80000010 -> next cycle out_valid=0, occupancy=0; 0x80000010 never appears.
REQ-035 Simultaneous push/pop at count=1 for 10 cycles across pointer wrap -> occupancy stays 1, PCs in order, none lost.
REQ-036 Reset mid-stream: occupancy=2, rst_n=0 one edge -> occupancy=0, out_valid=0 next cycle.
